bus_slave_alu: RTL

//  - Downstream target of the bus master: accepts register writes (valid/address/data) and a start strobe.
//  - Executes one operation on two latched operands; returns result_data with a one-cycle ready pulse.
//  - Multi-cycle: simple ALU ops complete in 2 cycles, optional multiply iterates over DATA_W cycles.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_slave_alu_seq_multiplier.sv | 69 ++++++
 rtl/bus_slave_alu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for bus_slave_alu.
// Opcodes, FSM states and register addresses.
package bus_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_OPA    = 2'd1;
  localparam logic [1:0] ADDR_OPB    = 2'd2;
  localparam logic [1:0] ADDR_OPCODE = 2'd3;

endpackage

// File: rtl/bus_slave_alu_seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per cycle.
// done pulses for one cycle once product holds the low DATA_W bits.
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CW'(DATA_W);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/bus_slave_alu.sv
// bus_slave_alu: register-mapped ALU target with start/ready handshake.
// Define BUS_SLAVE_ALU_MUL_EN to build the iterative multiplier for opcode 5.
import bus_pkg::*;

module bus_slave_alu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic [DATA_W-1:0] result_data,
  output logic              busy,
  output logic              err
);
  state_e            state_q, state_d;
  logic              ph_q, ph_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [2:0]        opc_q, opc_d;
  logic [DATA_W-1:0] sa_q, sa_d;
  logic [DATA_W-1:0] sb_q, sb_d;
  logic [2:0]        sop_q, sop_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_res;
  logic              bad_op;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;

`ifdef BUS_SLAVE_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
  logic mul_go;
  // Launch on the first EXEC cycle so the product lands DATA_W edges later.
  assign mul_go = (state_q == EXEC) && !ph_q && (sop_q == OP_MUL);
  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_go),
    .a       (sa_q),
    .b       (sb_q),
    .done    (mul_done),
    .product (mul_p)
  );
`else
  localparam bit MulEn = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif

  assign busy        = (state_q != IDLE);
  assign ready       = (state_q == DONE);
  assign result_data = res_q;
  assign err         = err_q;

  always_comb begin
    alu_res = '0;
    bad_op  = 1'b0;
    case (sop_q)
      OP_ADD:  alu_res = sa_q + sb_q;
      OP_SUB:  alu_res = sa_q - sb_q;
      OP_AND:  alu_res = sa_q & sb_q;
      OP_OR:   alu_res = sa_q | sb_q;
      OP_XOR:  alu_res = sa_q ^ sb_q;
      default: bad_op  = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sop_d   = sop_q;
    res_d   = res_q;
    err_d   = err_q;
    if (valid && !busy && address <= ADDR_W'(3)) begin
      case (address[1:0])
        ADDR_OPA:    opa_d = data;
        ADDR_OPB:    opb_d = data;
        ADDR_OPCODE: opc_d = data[2:0];
        default:     ;
      endcase
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = EXEC;
        ph_d    = 1'b0;
        sa_d    = opa_q;
        sb_d    = opb_q;
        sop_d   = opc_q;
        err_d   = 1'b0;
      end
      EXEC: if (!ph_q) begin
        ph_d = 1'b1;
      end else if (MulEn && sop_q == OP_MUL) begin
        state_d = MUL;
      end else begin
        state_d = DONE;
        res_d   = alu_res;
        if (bad_op) err_d = 1'b1;
      end
      MUL: if (mul_done) begin
        state_d = DONE;
        res_d   = mul_p;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A bad write on the start edge still flags, overriding the clear.
    if (valid && (busy || address > ADDR_W'(3))) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= OP_ADD;
      sa_q    <= '0;
      sb_q    <= '0;
      sop_q   <= OP_ADD;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sop_q   <= sop_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule
